// File: rtl/muldiv_sequencer_if.sv
// ============================================================================
//  muldiv_sequencer_if
//  Handshake, operand and shared-ALU bundle of the multiply/divide sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface muldiv_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] src_a_i;
  logic [WIDTH-1:0] src_b_i;
  logic [WIDTH-1:0] alu_result_i;
  logic             alu_sel_o;
  logic [WIDTH-1:0] alu_a_o;
  logic [WIDTH-1:0] alu_b_o;
  logic [3:0]       alu_operation_o;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  // Pipeline / ALU side.
  modport master (
    output start_i, op_i, src_a_i, src_b_i, alu_result_i,
    input  alu_sel_o, alu_a_o, alu_b_o, alu_operation_o,
    input  stall_o, busy_o, done_o, result_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, alu_result_i,
    output alu_sel_o, alu_a_o, alu_b_o, alu_operation_o,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  muldiv_sequencer
//  Iterative unsigned MUL/MULHU/DIVU/REMU using the shared EX-stage ALU for
//  one add/subtract per cycle. Define MULDIV_DIV_EN to build the divider.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus_io
);

  localparam int         CW      = $clog2(WIDTH);
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] hi_q;     // product high half / remainder
  logic [WIDTH-1:0] lo_q;     // product low half / quotient
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       aluop_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic             w_carry;
  logic             w_last;
  logic             w_accept;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   w_partial;
  logic             w_fit;
`endif

  assign w_accept = bus_io.start_i & (state_q != S_RUN);

  // One iteration of the selected algorithm, evaluated from the current pair.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    w_alu_a = '0;
    w_alu_b = '0;
    w_carry = 1'b0;
    w_last  = (cnt_q == {CW{1'b1}});
`ifdef MULDIV_DIV_EN
    w_partial = {hi_q, lo_q[WIDTH-1]};
    w_fit     = 1'b0;
`endif
    if (op_q[1]) begin
`ifdef MULDIV_DIV_EN
      w_alu_a = w_partial[WIDTH-1:0];
      w_alu_b = opnd_q;
      if (opnd_q == '0) begin
        hi_d   = lo_q;
        lo_d   = '1;
        w_last = 1'b1;
      end else begin
        w_fit = w_partial[WIDTH] | (w_partial[WIDTH-1:0] >= opnd_q);
        hi_d  = w_fit ? bus_io.alu_result_i : w_partial[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], w_fit};
      end
`endif
    end else begin
      w_alu_a = hi_q;
      w_alu_b = lo_q[0] ? opnd_q : '0;
      w_carry = (bus_io.alu_result_i < hi_q);
      hi_d    = {w_carry, bus_io.alu_result_i[WIDTH-1:1]};
      lo_d    = {bus_io.alu_result_i[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      aluop_q  <= ALU_ADD;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (w_accept) begin
            op_q   <= bus_io.op_i;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= bus_io.op_i[1] ? bus_io.src_a_i : bus_io.src_b_i;
            opnd_q <= bus_io.op_i[1] ? bus_io.src_b_i : bus_io.src_a_i;
`ifdef MULDIV_DIV_EN
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            aluop_q <= bus_io.op_i[1] ? ALU_SUB : ALU_ADD;
`else
            if (bus_io.op_i[1]) begin
              // No divider built: complete immediately with a zero result.
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= '0;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              aluop_q <= ALU_ADD;
            end
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (w_last) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            aluop_q  <= ALU_ADD;
            // op[0] picks the high half (MULHU) or remainder (REMU).
            result_q <= op_q[0] ? hi_d : lo_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.alu_sel_o       = busy_q;
  assign bus_io.alu_a_o         = busy_q ? w_alu_a : '0;
  assign bus_io.alu_b_o         = busy_q ? w_alu_b : '0;
  assign bus_io.alu_operation_o = aluop_q;
  assign bus_io.busy_o          = busy_q;
  assign bus_io.done_o          = done_q;
  assign bus_io.result_o        = result_q;
  assign bus_io.stall_o         = busy_q | (w_accept & ~reset);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
//  tb_muldiv_sequencer
//  Scoreboard bench for muldiv_sequencer at WIDTH=8 with a behavioural ALU.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  // The shared execute-stage ALU.
  assign bus.alu_result_i = (bus.alu_operation_o == 4'b0110) ?
                            (bus.alu_a_o - bus.alu_b_o) : (bus.alu_a_o + bus.alu_b_o);

  function automatic logic [W-1:0] model_res(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
`ifdef MULDIV_DIV_EN
      2'b10:   return (b == '0) ? {W{1'b1}} : a / b;
      default: return (b == '0) ? a : a % b;
`else
      default: return '0;
`endif
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] b);
    if (!op[1]) return W + 1;
`ifdef MULDIV_DIV_EN
    return (b == '0) ? 2 : W + 1;
`else
    return (b == '0) ? 1 : 1;
`endif
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src_a_i = a;
    bus.src_b_i = b;
    e.res = model_res(op, a, b);
    e.lat = model_lat(op, b);
    sb_q.push_back(e);
  endtask

  // Waits for done (bounded); releases start after the accepting edge.
  task automatic collect(output logic [W-1:0] r, output int lat, output bit to, output bit b1);
    lat = 0;
    b1  = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.start_i = 1'b0;
        b1 = bus.busy_o;
      end
    end while (bus.done_o !== 1'b1 && lat < 100);
    to = (bus.done_o !== 1'b1);
    r  = bus.result_o;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start_i = 1'b0; bus.op_i = '0; bus.src_a_i = '0; bus.src_b_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.alu_sel_o, bus.stall_o, bus.busy_o, bus.done_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000",
                      {bus.alu_sel_o, bus.stall_o, bus.busy_o, bus.done_o});
    end
    total++;
    if (bus.result_o !== '0 || bus.alu_a_o !== '0 || bus.alu_b_o !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h exp=00/00/00",
                      bus.result_o, bus.alu_a_o, bus.alu_b_o);
    end
    total++;
    if (bus.alu_operation_o !== 4'b0010) begin
      bad++; $display("FAIL reset_aluop got=%b exp=0010", bus.alu_operation_o);
    end
  endtask

  task automatic test_table(input string name, input logic [1:0] ops[],
                            input logic [W-1:0] as[], input logic [W-1:0] bs[]);
    logic [W-1:0] r; int lat; bit to; bit b1; exp_t e;
    for (int i = 0; i < ops.size(); i++) begin
      @(negedge clk);
      issue(ops[i], as[i], bs[i]);
      collect(r, lat, to, b1);
      e = sb_q.pop_front();
      total++;
      if (to || r !== e.res) begin
        bad++; $display("FAIL %s_res[%0d] op=%0d a=%h b=%h got=%h exp=%h timeout=%0d",
                        name, i, ops[i], as[i], bs[i], r, e.res, to);
      end
      total++;
      if (lat != e.lat) begin
        bad++; $display("FAIL %s_lat[%0d] got=%0d exp=%0d", name, i, lat, e.lat);
      end
    end
  endtask

  task automatic test_mul();
    logic [1:0]   ops[] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    logic [W-1:0] as[]  = '{8'd13, 8'd13, 8'hFF, 8'hFF, 8'h00, 8'h80};
    logic [W-1:0] bs[]  = '{8'd11, 8'd11, 8'hFF, 8'hFF, 8'h55, 8'h02};
    test_table("mul", ops, as, bs);
  endtask

  task automatic test_div();
    logic [1:0]   ops[] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
    logic [W-1:0] as[]  = '{8'd200, 8'd200, 8'h80, 8'hFF, 8'd5, 8'd5, 8'hFF};
    logic [W-1:0] bs[]  = '{8'd7, 8'd7, 8'h81, 8'h80, 8'd0, 8'd0, 8'h01};
    test_table("div", ops, as, bs);
  endtask

  task automatic test_random();
    logic [1:0] ops[]; logic [W-1:0] as[]; logic [W-1:0] bs[];
    ops = new[16]; as = new[16]; bs = new[16];
    for (int i = 0; i < 16; i++) begin
      ops[i] = 2'($urandom_range(0, 3));
      as[i]  = 8'($urandom);
      bs[i]  = (i % 5 == 4) ? 8'h00 : 8'($urandom);
    end
    test_table("rand", ops, as, bs);
  endtask

  task automatic test_protocol();
    int lat; exp_t e;
    @(negedge clk);
    issue(2'd0, 8'd13, 8'd11);
    #1;
    total++;
    if (bus.stall_o !== 1'b1 || bus.alu_sel_o !== 1'b0) begin
      bad++; $display("FAIL proto_start_cycle stall/alu_sel got=%b%b exp=10",
                      bus.stall_o, bus.alu_sel_o);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.done_o !== 1'b1) begin
        total++;
        if ({bus.stall_o, bus.busy_o, bus.alu_sel_o, bus.alu_operation_o} !== 7'b111_0010) begin
          bad++; $display("FAIL proto_run[%0d] got=%b exp=1110010", lat,
                          {bus.stall_o, bus.busy_o, bus.alu_sel_o, bus.alu_operation_o});
        end
      end
      if (lat == 1) bus.start_i = 1'b0;
      if (lat == 3) begin
        bus.start_i = 1'b1; bus.op_i = 2'd2; bus.src_a_i = 8'h99; bus.src_b_i = 8'h03;
      end
      if (lat == 4) bus.start_i = 1'b0;
    end while (bus.done_o !== 1'b1 && lat < 100);
    e = sb_q.pop_front();
    total++;
    if (bus.result_o !== e.res || lat != e.lat) begin
      bad++; $display("FAIL proto_ignore_start got=%h/%0d exp=%h/%0d",
                      bus.result_o, lat, e.res, e.lat);
    end
    total++;
    if ({bus.stall_o, bus.alu_sel_o, bus.busy_o} !== 3'b000) begin
      bad++; $display("FAIL proto_done_flags got=%b exp=000",
                      {bus.stall_o, bus.alu_sel_o, bus.busy_o});
    end
    @(negedge clk);
    total++;
    if ({bus.busy_o, bus.done_o} !== 2'b00) begin
      bad++; $display("FAIL proto_idle got=%b exp=00", {bus.busy_o, bus.done_o});
    end
    // Divide op: check ALU code on the first RUN cycle.
    issue(2'd2, 8'd200, 8'd7);
    @(negedge clk);
    bus.start_i = 1'b0;
    total++;
`ifdef MULDIV_DIV_EN
    if ({bus.alu_sel_o, bus.alu_operation_o} !== 5'b1_0110) begin
      bad++; $display("FAIL proto_div_aluop got=%b exp=10110",
                      {bus.alu_sel_o, bus.alu_operation_o});
    end
`else
    if ({bus.alu_sel_o, bus.done_o} !== 2'b01) begin
      bad++; $display("FAIL proto_nodiv_done got=%b exp=01", {bus.alu_sel_o, bus.done_o});
    end
`endif
    lat = 1;
    while (bus.done_o !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    total++;
    if (bus.result_o !== e.res || lat != e.lat) begin
      bad++; $display("FAIL proto_div_res got=%h/%0d exp=%h/%0d",
                      bus.result_o, lat, e.res, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r; int lat; bit to; bit b1; exp_t e;
    @(negedge clk);
    issue(2'd0, 8'hFF, 8'hFF);
    collect(r, lat, to, b1);
    e = sb_q.pop_front();
    total++;
    if (to || r !== e.res) begin
      bad++; $display("FAIL b2b_first got=%h exp=%h", r, e.res);
    end
    issue(2'd1, 8'hFF, 8'hFF);
    #1;
    total++;
    if (bus.result_o !== e.res || bus.stall_o !== 1'b1) begin
      bad++; $display("FAIL b2b_done_cycle result/stall got=%h/%b exp=%h/1",
                      bus.result_o, bus.stall_o, e.res);
    end
    collect(r, lat, to, b1);
    e = sb_q.pop_front();
    total++;
    if (b1 !== 1'b1) begin
      bad++; $display("FAIL b2b_no_bubble busy got=%b exp=1", b1);
    end
    total++;
    if (to || r !== e.res || lat != e.lat) begin
      bad++; $display("FAIL b2b_second got=%h/%0d exp=%h/%0d", r, lat, e.res, e.lat);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r; int lat; bit to; bit b1; exp_t e;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'd0; bus.src_a_i = 8'hAB; bus.src_b_i = 8'hCD;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.start_i = 1'b0;
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.alu_sel_o, bus.stall_o, bus.busy_o, bus.done_o} !== 4'b0000 ||
        bus.result_o !== '0 || bus.alu_a_o !== '0) begin
      bad++; $display("FAIL midrun_reset flags=%b result=%h alu_a=%h exp=0000/00/00",
                      {bus.alu_sel_o, bus.stall_o, bus.busy_o, bus.done_o},
                      bus.result_o, bus.alu_a_o);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.busy_o, bus.done_o} !== 2'b00) begin
      bad++; $display("FAIL midrun_idle got=%b exp=00", {bus.busy_o, bus.done_o});
    end
    issue(2'd0, 8'd3, 8'd5);
    collect(r, lat, to, b1);
    e = sb_q.pop_front();
    total++;
    if (to || r !== 8'd15 || r !== e.res || lat != e.lat) begin
      bad++; $display("FAIL midrun_fresh got=%h/%0d exp=0f/%0d", r, lat, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_protocol();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative unsigned multiply/divide controller that borrows the execute-stage ALU for one add or subtract per cycle. It lets the pipeline support M-extension style operations without a dedicated multiplier array. It sits beside the ALU operand mux in EX: while running it owns the ALU inputs and operation code, and it stalls the upstream stages until the result is ready.

## Interface
- WIDTH, 64, operand/result width in bits; must be a power of two, ≥ 4
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled in IDLE or DONE only
- op  input  2  00 MUL (low WIDTH bits), 01 MULHU (high WIDTH bits), 10 DIVU, 11 REMU
- src_a  input  WIDTH  multiplicand / dividend
- src_b  input  WIDTH  multiplier / divisor
- alu_result  input  WIDTH  result of the shared ALU
- alu_sel  output  1  1 = ALU inputs and operation driven by this block
- alu_a, alu_b  output  WIDTH  ALU operands
- alu_operation  output  4  ALU code: 0010 add, 0110 sub
- stall  output  1  hold IF/ID/EX pipeline registers
- busy  output  1  state is RUN
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  selected result; held until next accepted start

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0 except alu_operation = 0010; internal registers cleared.
- Accept: start high in IDLE or DONE → latch op/src_a/src_b, clear iteration counter, go to RUN. start in RUN is ignored.
- MUL/MULHU: the register pair {hi, lo} starts as {0, src_b}. For each iteration, alu_a = hi and alu_b = (lo[0] ? multiplicand : 0), with operation 0010. Carry-out is computed locally as (alu_result < alu_a). Then {hi, lo} ← {carry, alu_result, lo} >> 1. The final value is the product {hi, lo}.
- DIVU/REMU (restoring): rem starts at 0 and quo at the dividend. Each iteration shifts {rem, quo} left by 1 to form a (WIDTH+1)-bit partial remainder. The block drives alu_a = its low WIDTH bits, alu_b = divisor, operation 0110. fit = partial[WIDTH] | (partial ≥ divisor), compared locally. If fit, rem ← alu_result; otherwise rem ← partial[WIDTH-1:0]. The quotient LSB is set to fit.
- Divide by zero: no iterations. RUN → DONE after one cycle with quotient = all ones and remainder = dividend.
- result mux: MUL→lo, MULHU→hi, DIVU→quo, REMU→rem.
- alu_sel = busy. stall = busy | (start & state ∈ {IDLE, DONE}).
- All arithmetic is unsigned modulo 2^WIDTH. The counter is log2(WIDTH) bits wide and terminates at WIDTH-1.

## Timing
- Start accepted at edge E0. Iterations execute at edges E1..E_WIDTH, one per cycle. At E_WIDTH the block enters DONE, so done = 1 and result is valid in cycle E_WIDTH..E_WIDTH+1. The next edge returns to IDLE unless start is high.
- Total latency from start to done is WIDTH+1 cycles; the divide-by-zero case takes 2 cycles.
- stall is low in DONE, so EX captures result on the edge that ends DONE.
- Back-to-back: start high during DONE goes directly to RUN with no IDLE bubble. The previous result stays visible during that DONE cycle.
- Reset asserted mid-RUN: immediate return to IDLE; alu_sel, stall, busy, done and result = 0. The partial result is discarded.

## Configuration
- MULDIV_DIV_EN defined: all four ops are supported as described.
- MULDIV_DIV_EN undefined: the divide datapath and comparator are not built. DIVU/REMU skip RUN: accept → DONE in 1 cycle with result = 0. MUL/MULHU are unchanged.

## Test plan
- WIDTH=8, MUL 13×11 → done at cycle 9 after start; result = 0x8F; MULHU of the same operands → 0x00.
- WIDTH=8, MULHU 0xFF×0xFF → 0xFE; MUL → 0x01. Checks carry-out handling on every iteration.
- WIDTH=8, DIVU 200/7 → 28 (0x1C); REMU → 4. DIVU 0x80/0x81 → 0. REMU 0xFF/0x80 → 0x7F.
- DIVU 5/0 → 0xFF with done 2 cycles after start; REMU 5/0 → 5. Without MULDIV_DIV_EN, DIVU 200/7 → 0 after 1 cycle.
- Protocol: start during RUN is ignored. start in the DONE cycle begins a new op with no idle cycle. stall is high from the start cycle through RUN and low in DONE. alu_sel is high only in RUN, with alu_operation 0010 (mul) or 0110 (div).
- Assert reset at iteration 4 of a MUL → all outputs 0 that cycle, state IDLE. A fresh MUL 3×5 afterwards → 15.
